// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first with optional parity
// and one or two stop bits. The serial line is a registered output, idle high.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_uart,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                BIT_CNT   = CLK_FREQ / BAUD;
    localparam int                BAUD_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CNT - 1);
    localparam logic [3:0]        STOP_END  = 4'(STOP_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift_reg, shift_reg_n;
    logic              parity_bit, parity_bit_n;
    logic              line_n;
    logic              done_n;
    logic              accept;
    logic              baud_wrap;

    assign accept    = tx_valid && (state == S_IDLE);
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign tx_ready  = (state == S_IDLE);
    assign tx_busy   = (state != S_IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n      = state;
        baud_cnt_n   = baud_wrap ? '0 : baud_cnt + 1'b1;
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        line_n       = 1'b1;
        done_n       = 1'b0;

        unique case (state)
            S_IDLE: begin
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                if (accept) begin
                    state_n      = S_START;
                    shift_reg_n  = tx_data;
                    parity_bit_n = (PARITY == 1) ? ~^tx_data : ^tx_data;
                end
            end

            S_START: begin
                line_n = 1'b0;
                if (baud_wrap) begin
                    state_n = S_DATA;
                end
            end

            S_DATA: begin
                line_n = shift_reg[0];
                if (baud_wrap) begin
                    shift_reg_n = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end

            S_PARITY: begin
                line_n = parity_bit;
                if (baud_wrap) begin
                    state_n = S_STOP;
                end
            end

            S_STOP: begin
                // The line register trails the state by one cycle, so STOP holds one extra
                // cycle to let the last stop bit finish on the wire before returning to IDLE.
                if (bit_cnt == STOP_END) begin
                    state_n    = S_IDLE;
                    done_n     = 1'b1;
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                end else if (baud_wrap) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_uart    <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
            tx_uart    <= line_n;
            tx_done    <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity / odd+2 stop / even) on a short
// bit period, a cycle-level frame model, a behavioural line receiver and directed corner cases.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;
    localparam int NDUT     = 3;

    function automatic int par_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic int stop_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int nbits_of(input int i);
        return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i);
    endfunction

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      tx_data [NDUT];
    logic [NDUT-1:0] tx_valid;
    logic [NDUT-1:0] tx_ready;
    logic [NDUT-1:0] tx_uart;
    logic [NDUT-1:0] tx_busy;
    logic [NDUT-1:0] tx_done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx #(
            .CLK_FREQ (CLK_FREQ),
            .BAUD     (BAUD),
            .PARITY   ((g == 0) ? 0 : ((g == 1) ? 1 : 2)),
            .STOP_BITS((g == 1) ? 2 : 1)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .tx_data (tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .tx_uart (tx_uart[g]),
            .tx_busy (tx_busy[g]),
            .tx_done (tx_done[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Frame as a list of line bits: start, d0..d7, optional parity, stop bits (unused slots high).
    function automatic logic [11:0] frame_bits(input int i, input logic [7:0] d);
        logic [11:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[1+k] = d[k];
        if (par_of(i) == 1) f[9] = (($countones(d) % 2) == 0);
        else if (par_of(i) == 2) f[9] = (($countones(d) % 2) == 1);
        return f;
    endfunction

    // Reference model: cycles elapsed since accept; each frame bit occupies B cycles after a
    // one-cycle latency, and the frame ends 1 + nbits*B cycles after the accept edge.
    logic        m_busy [NDUT];
    logic        m_done [NDUT];
    int          m_pos  [NDUT];
    logic [11:0] m_bits [NDUT];

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_pos[i]  = 0;
            end else if (!m_busy[i] && tx_valid[i]) begin
                m_bits[i] = frame_bits(i, tx_data[i]);
                m_busy[i] = 1'b1;
                m_pos[i]  = 0;
                m_done[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_pos[i]++;
                if (m_pos[i] == 1 + nbits_of(i) * B) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end else begin
                    m_done[i] = 1'b0;
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    end

    function automatic logic exp_line(input int i);
        if (m_busy[i] && m_pos[i] > 0) return m_bits[i][(m_pos[i] - 1) / B];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("cycle_dut%0d{line,ready,busy,done}", i),
                      {28'd0, tx_uart[i], tx_ready[i], tx_busy[i], tx_done[i]},
                      {28'd0, exp_line(i), !m_busy[i], m_busy[i], m_done[i]});
            end
        end
    end

    // Raise valid, wait for ready, let the accept edge pass; returns at the first negedge after it.
    task automatic start_frame(input int i, input logic [7:0] d, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (tx_ready[i]) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("accept_dut%0d", i), {31'd0, acc}, 32'd1);
        if (acc) @(posedge clk);
        @(negedge clk);
        tx_valid[i] = 1'b0;
    endtask

    // Sends one byte and decodes the line at bit centres like a receiver would.
    task automatic send_frame(input int i, input logic [7:0] d, output int len,
                              output logic [7:0] rx, output logic bit9);
        bit          acc;
        logic [11:0] smp;
        smp = '1;
        len = -1;
        start_frame(i, d, acc);
        if (acc) begin
            for (int t = 0; t < 400; t++) begin
                for (int b = 0; b < 12; b++) begin
                    if (t == 1 + b * B + B / 2) smp[b] = tx_uart[i];
                end
                if (tx_done[i]) begin
                    len = t;
                    break;
                end
                @(negedge clk);
            end
        end
        rx   = smp[8:1];
        bit9 = smp[9];
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       bit9;
        int         len;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         len;
        logic [7:0] rx;
        logic       bit9;
        bit         acc;
        int         dcnt;
        int         first_done;
        int         low2;
        int         low_in_rst;

        vecs[0] = '{0, 8'h55, 1'b1, 1 + 10 * B};
        vecs[1] = '{2, 8'hA3, 1'b0, 1 + 11 * B};
        vecs[2] = '{1, 8'hA3, 1'b1, 1 + 12 * B};
        vecs[3] = '{1, 8'h07, 1'b0, 1 + 12 * B};
        vecs[4] = '{2, 8'h07, 1'b1, 1 + 11 * B};
        vecs[5] = '{0, 8'hC9, 1'b1, 1 + 10 * B};
        vecs[6] = '{1, 8'h00, 1'b1, 1 + 12 * B};
        vecs[7] = '{2, 8'hFF, 1'b0, 1 + 11 * B};

        // Reset held with tx_valid high: everything stays idle, no start bit.
        for (int i = 0; i < NDUT; i++) begin
            tx_data[i]  = 8'hA5;
            tx_valid[i] = 1'b1;
        end
        @(posedge clk);
        chk_en     = 1'b1;
        low_in_rst = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) if (tx_uart[i] == 1'b0 || tx_busy[i]) low_in_rst++;
        end
        check("reset_no_activity", low_in_rst, 0);
        check("reset_ready", {29'd0, tx_ready}, {29'd0, 3'b111});
        check("reset_done", {29'd0, tx_done}, 32'd0);
        rst      = 1'b0;
        tx_valid = '0;
        repeat (5) @(negedge clk);

        // Table-driven frames across the three configurations.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].dut, vecs[v].data, len, rx, bit9);
            check($sformatf("vec%0d_data", v), {24'd0, rx}, {24'd0, vecs[v].data});
            check($sformatf("vec%0d_bit9", v), {31'd0, bit9}, {31'd0, vecs[v].bit9});
            check($sformatf("vec%0d_len", v), len, vecs[v].len);
        end

        // Back-to-back with tx_valid held: 0x00 then 0xFF on the no-parity instance.
        @(negedge clk);
        tx_data[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        dcnt        = 0;
        first_done  = -1;
        low2        = -1;
        for (int c = 0; c < 2 * (2 + 10 * B) + 20; c++) begin
            @(negedge clk);
            if (dcnt == 1 && low2 < 0 && tx_uart[0] == 1'b0) low2 = c;
            if (tx_done[0]) begin
                dcnt++;
                if (dcnt == 1) begin
                    first_done = c;
                    tx_data[0] = 8'hFF;
                end else begin
                    tx_valid[0] = 1'b0;
                end
            end
        end
        tx_valid[0] = 1'b0;
        check("b2b_done_pulses", dcnt, 2);
        check("b2b_start_gap", low2 - first_done, 2);

        // Reset during data bit 3 of 0x0F: frame aborts, line high, no tx_done.
        start_frame(0, 8'h0F, acc);
        repeat (1 + 4 * B + B / 2) @(negedge clk);
        check("midrst_busy_before", {31'd0, tx_busy[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_line", {31'd0, tx_uart[0]}, 32'd1);
        check("midrst_ready", {31'd0, tx_ready[0]}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (2 * (1 + 10 * B)) begin
            @(negedge clk);
            if (tx_done[0]) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        send_frame(0, 8'hA5, len, rx, bit9);
        check("postrst_data", {24'd0, rx}, 32'hA5);
        check("postrst_len", len, 1 + 10 * B);

        // Randomized traffic against the frame rules.
        for (int n = 0; n < 12; n++) begin
            int         i;
            logic [7:0] d;
            logic [11:0] f;
            i = $urandom_range(0, NDUT - 1);
            d = 8'($urandom);
            f = frame_bits(i, d);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_frame(i, d, len, rx, bit9);
            check($sformatf("rand%0d_data", n), {24'd0, rx}, {24'd0, d});
            check($sformatf("rand%0d_bit9", n), {31'd0, bit9}, {31'd0, f[9]});
            check($sformatf("rand%0d_len", n), len, 1 + nbits_of(i) * B);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
